// File: rtl/adder_arbiter.sv
// adder_arbiter: round-robin arbiter that shares one WIDTH-bit adder between
// N_REQ requesters. Stage S1 registers the winning operand pair and its index.
// Stage S2 registers the sum and carry and presents them on the tagged response
// port.
//
// Handshake semantics, identical on both sides:
//   A transfer happens on a rising clock edge where valid && ready are both
//   high. The producer may drop valid at any time. Requesters do not have to
//   hold req_valid. rsp_* are held stable while rsp_valid && !rsp_ready.
//   req_ready is one-hot or all-zero. It is only ever high for a requester
//   whose req_valid is high.
module adder_arbiter #(
  parameter  int N_REQ = 4,
  parameter  int WIDTH = 8,
  localparam int ID_W  = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  output logic [N_REQ-1:0]       req_ready,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ID_W-1:0]        rsp_id,
  output logic [WIDTH-1:0]       rsp_sum,
  output logic                   rsp_carry,
  output logic                   busy
);

  // Unpacked operand views, so that the winner can be selected by index.
  logic [WIDTH-1:0] a_arr [N_REQ];
  logic [WIDTH-1:0] b_arr [N_REQ];

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
    assign a_arr[gi] = req_a[gi*WIDTH +: WIDTH];
    assign b_arr[gi] = req_b[gi*WIDTH +: WIDTH];
  end

  // Round-robin pointer.
  logic [ID_W-1:0]  ptr_q, ptr_d;

  // S1: operand register.
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic             s1_valid_q, s1_valid_d;

  // S2: result register, which drives the response port directly.
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic [ID_W-1:0]  rsp_id_q, rsp_id_d;
  logic             rsp_valid_q, rsp_valid_d;

  logic             s2_free;
  logic             s1_free;
  logic [N_REQ-1:0] grant;
  logic             grant_any;
  logic [ID_W-1:0]  grant_id;
  logic [WIDTH:0]   sum_full;

  assign s2_free = !rsp_valid_q || rsp_ready;
  assign s1_free = !s1_valid_q || s2_free;

  // Round-robin search: scan upward from ptr with wrap, and take the first
  // valid requester. The search is only allowed when S1 can accept data.
  always_comb begin
    int idx_i;
    logic [ID_W-1:0] idx;
    grant     = '0;
    grant_any = 1'b0;
    grant_id  = '0;
    idx_i     = 0;
    idx       = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx_i = (int'(ptr_q) + k) % N_REQ;
      idx   = ID_W'(idx_i);
      if (!grant_any && req_valid[idx]) begin
        grant_any   = 1'b1;
        grant[idx]  = 1'b1;
        grant_id    = idx;
      end
    end
    if (!s1_free) begin
      grant     = '0;
      grant_any = 1'b0;
      grant_id  = '0;
    end
  end

  // Grant is masked during reset. Otherwise the empty pipeline would make it
  // look as if requests were being accepted.
  assign req_ready = rst_n ? grant : '0;

  // The adder is computed one bit wider, so that the top bit is the carry out.
  assign sum_full = {1'b0, a_q} + {1'b0, b_q};

  // Next-state logic for the pointer and both pipeline stages.
  always_comb begin
    ptr_d       = ptr_q;
    a_d         = a_q;
    b_d         = b_q;
    id_d        = id_q;
    s1_valid_d  = s1_valid_q;
    sum_d       = sum_q;
    carry_d     = carry_q;
    rsp_id_d    = rsp_id_q;
    rsp_valid_d = rsp_valid_q;

    // The pointer moves just past the winner, so that the winner becomes the
    // lowest priority on the next search.
    if (grant_any) begin
      ptr_d = ID_W'((int'(grant_id) + 1) % N_REQ);
    end

    // S1 refills on a grant. It empties when it is free and nobody wins.
    if (s1_free) begin
      if (grant_any) begin
        a_d        = a_arr[grant_id];
        b_d        = b_arr[grant_id];
        id_d       = grant_id;
        s1_valid_d = 1'b1;
      end else begin
        s1_valid_d = 1'b0;
      end
    end

    // S2 takes S1's result whenever it is free. It holds while the consumer
    // stalls.
    if (s2_free) begin
      if (s1_valid_q) begin
        sum_d       = sum_full[WIDTH-1:0];
        carry_d     = sum_full[WIDTH];
        rsp_id_d    = id_q;
        rsp_valid_d = 1'b1;
      end else begin
        rsp_valid_d = 1'b0;
      end
    end
  end

  // State registers. The asynchronous reset discards any in-flight operations.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      id_q        <= '0;
      s1_valid_q  <= 1'b0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      rsp_id_q    <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      a_q         <= a_d;
      b_q         <= b_d;
      id_q        <= id_d;
      s1_valid_q  <= s1_valid_d;
      sum_q       <= sum_d;
      carry_q     <= carry_d;
      rsp_id_q    <= rsp_id_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_sum   = sum_q;
  assign rsp_carry = carry_q;
  assign rsp_id    = rsp_id_q;
  assign busy      = s1_valid_q || rsp_valid_q;

endmodule

// File: tb/tb_adder_arbiter.sv
// Bench for adder_arbiter: a table of per-cycle vectors with hand-derived
// grant and rsp_valid expectations. A scoreboard queue holds the expected
// {id, carry, sum} of every accepted operation. The bench finishes with a
// hand-written asynchronous reset sequence.
module tb_adder_arbiter;
  localparam int N  = 4;
  localparam int W  = 8;
  localparam int IW = 2;
  localparam int EW = IW + 1 + W;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [N*W-1:0] req_a = '0;
  logic [N*W-1:0] req_b = '0;
  logic [N-1:0]   req_ready;
  logic           rsp_valid;
  logic           rsp_ready = 1'b0;
  logic [IW-1:0]  rsp_id;
  logic [W-1:0]   rsp_sum;
  logic           rsp_carry;
  logic           busy;

  // Clock and reset.
  always #5 clk = ~clk;

  adder_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .rsp_carry (rsp_carry),
    .busy      (busy)
  );

  typedef struct {
    logic [N-1:0]   valid;
    logic [N*W-1:0] a;
    logic [N*W-1:0] b;
    logic           rsp_ready;
    logic [N-1:0]   exp_ready;
    logic           exp_rsp_valid;
  } vec_t;

  vec_t           vecs[$];
  logic [EW-1:0]  exp_q[$];
  int             errors = 0;
  int             checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Adds one cycle's vector. The operands are random, except that requester
  // op_req, when it is non-negative, is given the operand pair op_a/op_b.
  function automatic void add_vec(input logic [N-1:0] valid, input logic rdy,
                                  input logic [N-1:0] exp_ready, input logic exp_rv,
                                  input int op_req = -1,
                                  input logic [W-1:0] op_a = '0,
                                  input logic [W-1:0] op_b = '0);
    vec_t v;
    v.valid = valid;
    v.rsp_ready = rdy;
    v.exp_ready = exp_ready;
    v.exp_rsp_valid = exp_rv;
    for (int i = 0; i < N; i++) begin
      v.a[i*W +: W] = W'($urandom_range(0, (1 << W) - 1));
      v.b[i*W +: W] = W'($urandom_range(0, (1 << W) - 1));
    end
    if (op_req >= 0) begin
      v.a[op_req*W +: W] = op_a;
      v.b[op_req*W +: W] = op_b;
    end
    vecs.push_back(v);
  endfunction

  // Driver and scoreboard for one cycle. Call it just after a rising edge.
  task automatic apply_vec(input vec_t v);
    logic fire;
    logic [W:0] s;
    req_valid = v.valid;
    req_a     = v.a;
    req_b     = v.b;
    rsp_ready = v.rsp_ready;
    @(negedge clk);
    check("req_ready", 32'(req_ready), 32'(v.exp_ready));
    check("rsp_valid", 32'(rsp_valid), 32'(v.exp_rsp_valid));
    check("busy", 32'(busy), 32'(exp_q.size() != 0));
    if (rsp_valid) begin
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", 32'(1), 32'(0));
      end else begin
        check("rsp_data", 32'({rsp_id, rsp_carry, rsp_sum}), 32'(exp_q[0]));
      end
    end
    fire = rsp_valid && v.rsp_ready;
    @(posedge clk);
    if (fire && exp_q.size() != 0) void'(exp_q.pop_front());
    for (int i = 0; i < N; i++) begin
      if (v.exp_ready[i]) begin
        s = {1'b0, v.a[i*W +: W]} + {1'b0, v.b[i*W +: W]};
        exp_q.push_back({IW'(i), s});
      end
    end
    #1;
  endtask

  initial begin
    // Reset the DUT, and check its state while rst_n is held low.
    req_valid = '1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rsp_valid", 32'(rsp_valid), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_req_ready", 32'(req_ready), 32'(0));
    check("rst_rsp_sum", 32'(rsp_sum), 32'(0));
    req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single operation, requester 2: 7F + 01 = 80 with no carry. ptr becomes 3.
    add_vec(4'b0100, 1'b1, 4'b0100, 1'b0, 2, 8'h7F, 8'h01);
    add_vec(4'b0000, 1'b1, 4'b0000, 1'b0);
    add_vec(4'b0000, 1'b1, 4'b0000, 1'b1);
    add_vec(4'b0000, 1'b1, 4'b0000, 1'b0);
    // Carry and wrap. FF+02 comes from requester 0 (search 3 -> 0). FF+01 comes
    // from requester 1. ptr becomes 2.
    add_vec(4'b0001, 1'b1, 4'b0001, 1'b0, 0, 8'hFF, 8'h02);
    add_vec(4'b0010, 1'b1, 4'b0010, 1'b0, 1, 8'hFF, 8'h01);
    add_vec(4'b0000, 1'b1, 4'b0000, 1'b1);
    add_vec(4'b0000, 1'b1, 4'b0000, 1'b1);
    add_vec(4'b0000, 1'b1, 4'b0000, 1'b0);
    // Fairness: all requesters valid, starting from ptr=2. ptr ends at 2.
    for (int i = 0; i < 8; i++) begin
      add_vec(4'b1111, 1'b1, 4'(1 << ((i + 2) % N)), (i >= 2));
    end
    add_vec(4'b0000, 1'b1, 4'b0000, 1'b1);
    add_vec(4'b0000, 1'b1, 4'b0000, 1'b1);
    add_vec(4'b0000, 1'b1, 4'b0000, 1'b0);
    // Backpressure: exactly two grants (2, 3), then a stall with rsp held.
    add_vec(4'b1111, 1'b0, 4'b0100, 1'b0);
    add_vec(4'b1111, 1'b0, 4'b1000, 1'b0);
    add_vec(4'b1111, 1'b0, 4'b0000, 1'b1);
    add_vec(4'b1111, 1'b0, 4'b0000, 1'b1);
    add_vec(4'b1111, 1'b0, 4'b0000, 1'b1);
    // Release: the pipeline drains in order, and grants resume at requester 0.
    add_vec(4'b1111, 1'b1, 4'b0001, 1'b1);
    add_vec(4'b1111, 1'b1, 4'b0010, 1'b1);
    add_vec(4'b0000, 1'b1, 4'b0000, 1'b1);
    add_vec(4'b0000, 1'b1, 4'b0000, 1'b1);
    add_vec(4'b0000, 1'b1, 4'b0000, 1'b0);
    // Sparse: only requesters 1 and 3 valid, ptr=2 -> grants 3, 1, 3, 1.
    add_vec(4'b1010, 1'b1, 4'b1000, 1'b0);
    add_vec(4'b1010, 1'b1, 4'b0010, 1'b0);
    add_vec(4'b1010, 1'b1, 4'b1000, 1'b1);
    add_vec(4'b1010, 1'b1, 4'b0010, 1'b1);
    add_vec(4'b0000, 1'b1, 4'b0000, 1'b1);
    add_vec(4'b0000, 1'b1, 4'b0000, 1'b1);
    add_vec(4'b0000, 1'b1, 4'b0000, 1'b0);

    foreach (vecs[i]) apply_vec(vecs[i]);

    // Reset mid-stream: fill both stages (grants 2 and 3, from ptr=2), then
    // pull rst_n low in the middle of a cycle.
    vecs.delete();
    add_vec(4'b1111, 1'b0, 4'b0100, 1'b0);
    add_vec(4'b1111, 1'b0, 4'b1000, 1'b0);
    foreach (vecs[i]) apply_vec(vecs[i]);
    req_valid = '1;
    rsp_ready = 1'b0;
    #2;
    check("full_busy", 32'(busy), 32'(1));
    rst_n = 1'b0;
    #1;
    check("mid_rst_rsp_valid", 32'(rsp_valid), 32'(0));
    check("mid_rst_busy", 32'(busy), 32'(0));
    check("mid_rst_rsp_sum", 32'(rsp_sum), 32'(0));
    check("mid_rst_rsp_carry", 32'(rsp_carry), 32'(0));
    check("mid_rst_rsp_id", 32'(rsp_id), 32'(0));
    check("mid_rst_req_ready", 32'(req_ready), 32'(0));
    @(posedge clk);
    #1;
    check("rst_hold_req_ready", 32'(req_ready), 32'(0));
    check("rst_hold_rsp_valid", 32'(rsp_valid), 32'(0));
    exp_q.delete();
    req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // After the release, the first grant goes to requester 0. No stale
    // response may appear.
    vecs.delete();
    add_vec(4'b1111, 1'b1, 4'b0001, 1'b0);
    add_vec(4'b1111, 1'b1, 4'b0010, 1'b0);
    add_vec(4'b0000, 1'b1, 4'b0000, 1'b1);
    add_vec(4'b0000, 1'b1, 4'b0000, 1'b1);
    add_vec(4'b0000, 1'b1, 4'b0000, 1'b0);
    foreach (vecs[i]) apply_vec(vecs[i]);

    check("scoreboard_empty", 32'(exp_q.size()), 32'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
